// File: rtl/sysid_check_master.sv
`default_nettype none
// ============================================================================
// Module      : sysid_check_master
// Description : Avalon-MM read initiator that fetches the system ID (word 0)
//               and build timestamp (word 1) from the sysid responder,
//               compares them against expected constants and reports a
//               registered pass/fail status with per-word mismatch flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sysid_check_master #(
    parameter logic [31:0] EXPECTED_ID = 32'h0400_0000,
    parameter logic [31:0] EXPECTED_TS = 32'h5480_E45A,
    parameter bit          CHECK_TS    = 1'b1,
    parameter bit          AUTO_START  = 1'b1,
    parameter int          TIMEOUT     = 1023,
    parameter int          TO_W        = 10
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ_ID  = 3'd1,
        S_WAIT_ID = 3'd2,
        S_REQ_TS  = 3'd3,
        S_WAIT_TS = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [TO_W-1:0] c_timeout = TO_W'(TIMEOUT);

    state_t          r_state;
    logic [TO_W-1:0] r_cnt;
    logic            r_auto_pend;
    logic            r_id_got;
    logic            r_ts_got;

    logic            w_in_req;
    logic            w_in_wait;
    logic            w_accept;
    logic            w_rdv;
    logic            w_expire;
    logic            w_go;
    logic            w_id_mm;
    logic            w_ts_mm;
    logic [TO_W-1:0] w_cnt_inc;

    // Transaction qualifiers: a request completes on accept, a wait on valid
    // data; readdatavalid seen in any other state (including the accept
    // cycle, which is still a REQ state) is ignored by construction.
    always_comb begin
        w_in_req  = (r_state == S_REQ_ID)  || (r_state == S_REQ_TS);
        w_in_wait = (r_state == S_WAIT_ID) || (r_state == S_WAIT_TS);
        w_accept  = w_in_req && avm_read && !avm_waitrequest;
        w_rdv     = w_in_wait && avm_readdatavalid;
        // The counter saturates at the limit so that a request accepted in
        // the very last allowed cycle still gets exactly one more cycle to
        // deliver its data before aborting, without wrapping.
        w_cnt_inc = (r_cnt == c_timeout) ? r_cnt : r_cnt + TO_W'(1);
        w_expire  = (w_in_req || w_in_wait) && (r_cnt == c_timeout)
                    && !w_accept && !w_rdv;
        w_go      = (r_state == S_IDLE) && (start || r_auto_pend);
        // Only words actually received can be judged as mismatching.
        w_id_mm   = r_id_got && (id_value != EXPECTED_ID);
        w_ts_mm   = r_ts_got && (ts_value != EXPECTED_TS);
    end

    // Check sequencer with all bus and status outputs registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_auto_pend <= AUTO_START;
            r_id_got    <= 1'b0;
            r_ts_got    <= 1'b0;
            avm_address <= 1'b0;
            avm_read    <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            // The automatic check is only offered in the first cycle after
            // reset release.
            r_auto_pend <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state     <= S_REQ_ID;
                        r_cnt       <= '0;
                        r_id_got    <= 1'b0;
                        r_ts_got    <= 1'b0;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b0;
                        id_value    <= '0;
                        ts_value    <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        id_mismatch <= 1'b0;
                        ts_mismatch <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                S_REQ_ID, S_REQ_TS: begin
                    r_cnt <= w_cnt_inc;
                    if (w_accept) begin
                        avm_read <= 1'b0;
                        r_state  <= (r_state == S_REQ_ID) ? S_WAIT_ID : S_WAIT_TS;
                    end else if (w_expire) begin
                        avm_read <= 1'b0;
                        timeout  <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_WAIT_ID: begin
                    r_cnt <= w_cnt_inc;
                    if (w_rdv) begin
                        id_value    <= avm_readdata;
                        r_id_got    <= 1'b1;
                        r_cnt       <= '0;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b1;
                        r_state     <= S_REQ_TS;
                    end else if (w_expire) begin
                        timeout <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_WAIT_TS: begin
                    r_cnt <= w_cnt_inc;
                    if (w_rdv) begin
                        ts_value <= avm_readdata;
                        r_ts_got <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (w_expire) begin
                        timeout <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    id_mismatch <= w_id_mm;
                    ts_mismatch <= w_ts_mm;
                    pass        <= !w_id_mm && !(CHECK_TS && w_ts_mm) && !timeout;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    avm_read <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sysid_check_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_sysid_check_master
// Description : Self-checking bench for sysid_check_master. Two instances
//               (timestamp checked / timestamp captured only) share one
//               randomized Avalon responder; results are compared against a
//               per-transaction cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sysid_check_master;

    localparam logic [31:0] EXP_ID = 32'h0400_0000;
    localparam logic [31:0] EXP_TS = 32'h5480_E45A;
    localparam int          TMO    = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        wr;
    logic        resp_rdv;
    logic [31:0] resp_rdata;
    logic        poke_rdv;
    logic        rdv;
    logic [31:0] rdata;

    logic        a_addr, a_read, a_busy, a_done, a_pass, a_idm, a_tsm, a_to;
    logic [31:0] a_id, a_ts;
    logic        b_addr, b_read, b_busy, b_done, b_pass, b_idm, b_tsm, b_to;
    logic [31:0] b_id, b_ts;

    assign rdv   = resp_rdv | poke_rdv;
    assign rdata = poke_rdv ? 32'hDEAD_BEEF : resp_rdata;

    always #5 clk = ~clk;

    sysid_check_master #(.CHECK_TS(1'b1), .AUTO_START(1'b1), .TIMEOUT(TMO), .TO_W(5)) u_a (
        .clock(clk), .reset_n(reset_n), .start(start),
        .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(wr),
        .avm_readdata(rdata), .avm_readdatavalid(rdv),
        .id_value(a_id), .ts_value(a_ts), .busy(a_busy), .done(a_done),
        .pass(a_pass), .id_mismatch(a_idm), .ts_mismatch(a_tsm), .timeout(a_to));

    sysid_check_master #(.CHECK_TS(1'b0), .AUTO_START(1'b1), .TIMEOUT(TMO), .TO_W(5)) u_b (
        .clock(clk), .reset_n(reset_n), .start(start),
        .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(wr),
        .avm_readdata(rdata), .avm_readdatavalid(rdv),
        .id_value(b_id), .ts_value(b_ts), .busy(b_busy), .done(b_done),
        .pass(b_pass), .id_mismatch(b_idm), .ts_mismatch(b_tsm), .timeout(b_to));

    // Responder configuration for the current check
    int          cfg_stall [2];
    int          cfg_lat   [2];
    logic [31:0] cfg_data  [2];
    bit          cfg_nv    [2];
    bit          cfg_garb;

    int n_assert = 0;
    int n_fail   = 0;

    // Monitor bookkeeping
    logic q_acc [$];
    int   unstable = 0;
    int   ab_diff  = 0;
    bit   allow_drop = 0;
    bit   prev_stall = 0;
    logic prev_addr  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Responder: stalls each read cfg_stall cycles, returns data cfg_lat
    // cycles after accept, optionally sprays junk valid data during requests.
    initial begin
        int stall_cnt;
        int countdown;
        int pend;
        stall_cnt = 0; countdown = 0; pend = 0;
        wr = 1'b1; resp_rdv = 1'b0; resp_rdata = '0;
        forever begin
            @(posedge clk); #1;
            resp_rdv   = 1'b0;
            resp_rdata = $urandom;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    resp_rdv   = 1'b1;
                    resp_rdata = cfg_data[pend];
                end
            end
            if (a_read === 1'b1) begin
                if (cfg_garb) begin
                    resp_rdv   = 1'b1;
                    resp_rdata = ~cfg_data[a_addr];
                end
                if (stall_cnt < cfg_stall[a_addr]) begin
                    wr = 1'b1;
                    stall_cnt++;
                end else begin
                    wr = 1'b0;
                    stall_cnt = 0;
                    if (!cfg_nv[a_addr]) begin
                        countdown = cfg_lat[a_addr];
                        pend      = int'(a_addr);
                    end
                end
            end else begin
                wr = 1'($urandom_range(0, 1));
                stall_cnt = 0;
            end
        end
    end

    // Bus monitor: records accepted addresses, request stability, A/B equality
    always @(negedge clk) begin
        if (a_read === 1'b1 && wr === 1'b0) q_acc.push_back(a_addr);
        if (prev_stall && reset_n && !allow_drop && (a_read !== 1'b1 || a_addr !== prev_addr))
            unstable++;
        prev_stall = (a_read === 1'b1) && (wr === 1'b1) && reset_n;
        prev_addr  = a_addr;
        if (a_read !== b_read || a_addr !== b_addr) ab_diff++;
    end

    // One read transaction: accept at cycle s, data at s+l; a completion in
    // a cycle beats the limit, otherwise the first cycle at/after TMO aborts.
    function automatic void txn_model(input int s, input int l, input bit nv,
                                      output bit ok, output bit acc, output int cyc);
        bit comp;
        ok = 0; acc = 0; cyc = 0;
        for (int idx = 0; idx < 1000; idx++) begin
            comp = (idx == s) || (!nv && idx == s + l);
            if (!nv && idx == s + l) begin
                ok = 1; acc = 1; cyc = idx + 1;
                return;
            end
            if (!comp && idx >= TMO) begin
                ok = 0; acc = (s < idx); cyc = idx + 1;
                return;
            end
        end
    endfunction

    task automatic set_cfg(input int s0, input int s1, input int l0, input int l1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input bit nv0, input bit nv1, input bit garb);
        cfg_stall[0] = s0; cfg_stall[1] = s1;
        cfg_lat[0]   = l0; cfg_lat[1]   = l1;
        cfg_data[0]  = d0; cfg_data[1]  = d1;
        cfg_nv[0]    = nv0; cfg_nv[1]   = nv1;
        cfg_garb     = garb;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".read"}, {31'd0, a_read}, 0);
        chk({tag, ".addr"}, {31'd0, a_addr}, 0);
        chk({tag, ".stat"}, {26'd0, a_busy, a_done, a_pass, a_idm, a_tsm, a_to}, 0);
        chk({tag, ".id"},   a_id, 0);
        chk({tag, ".ts"},   a_ts, 0);
        chk({tag, ".b"},    {25'd0, b_read, b_busy, b_done, b_pass, b_idm, b_tsm, b_to}, 0);
    endtask

    // Run one check with the current config; use_start=0 means it was
    // launched by reset release (auto start).
    task automatic run_check(input string tag, input bit use_start, input bit poke);
        bit ok0, acc0, ok1, acc1;
        int c0, c1, exp_lat, idx, n_acc;
        bit idm, tsm, to;
        logic [31:0] hold_id;
        txn_model(cfg_stall[0], cfg_lat[0], cfg_nv[0], ok0, acc0, c0);
        ok1 = 0; acc1 = 0; c1 = 0;
        if (ok0) txn_model(cfg_stall[1], cfg_lat[1], cfg_nv[1], ok1, acc1, c1);
        exp_lat    = 1 + c0 + c1 + 1;
        allow_drop = !acc0 || (ok0 && !acc1);
        q_acc.delete();
        unstable = 0;
        ab_diff  = 0;
        if (use_start) begin
            @(negedge clk); start = 1'b1;
        end
        @(negedge clk); start = 1'b0;
        chk({tag, ".busy_on"}, {31'd0, a_busy, a_done}, 32'd2);
        idx = 0;
        while (a_done !== 1'b1 && idx < 200) begin
            start = (poke && idx == 2);
            @(negedge clk);
            idx++;
        end
        start = 1'b0;
        idm = ok0 && (cfg_data[0] != EXP_ID);
        tsm = ok1 && (cfg_data[1] != EXP_TS);
        to  = !(ok0 && ok1);
        chk({tag, ".latency"}, 32'(idx + 1), 32'(exp_lat));
        chk({tag, ".id"}, a_id, ok0 ? cfg_data[0] : 32'd0);
        chk({tag, ".ts"}, a_ts, ok1 ? cfg_data[1] : 32'd0);
        chk({tag, ".flags"}, {27'd0, a_busy, a_pass, a_idm, a_tsm, a_to},
            {27'd0, 1'b0, !idm && !tsm && !to, idm, tsm, to});
        chk({tag, ".b_flags"}, {26'd0, b_done, b_busy, b_pass, b_idm, b_tsm, b_to},
            {26'd0, 1'b1, 1'b0, !idm && !to, idm, tsm, to});
        n_acc = int'(acc0) + int'(acc1);
        chk({tag, ".n_reads"}, 32'(q_acc.size()), 32'(n_acc));
        if (q_acc.size() > 0) chk({tag, ".addr0"}, {31'd0, q_acc[0]}, 0);
        if (q_acc.size() > 1) chk({tag, ".addr1"}, {31'd0, q_acc[1]}, 1);
        chk({tag, ".stable"}, 32'(unstable), 0);
        chk({tag, ".a_eq_b"}, 32'(ab_diff), 0);
        // Status holds, stray valid data in IDLE is ignored, no queued start
        hold_id = a_id;
        poke_rdv = 1'b1;
        @(negedge clk);
        poke_rdv = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, ".hold"}, {30'd0, a_done, a_busy}, 32'd2);
        chk({tag, ".hold_id"}, a_id, hold_id);
        chk({tag, ".no_extra"}, 32'(q_acc.size()), 32'(n_acc));
        allow_drop = 0;
    endtask

    initial begin
        bit hit;
        reset_n = 1'b0; start = 1'b0; poke_rdv = 1'b0;
        set_cfg(0, 0, 1, 1, EXP_ID, EXP_TS, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset_n = 1'b1;
        run_check("T1_auto", 0, 0);

        set_cfg(5, 5, 1, 1, EXP_ID, EXP_TS, 0, 0, 0);
        run_check("T2_stall", 1, 1);
        set_cfg(0, 0, 1, 1, 32'h0400_0001, EXP_TS, 0, 0, 1);
        run_check("T3_id_bad", 1, 0);
        set_cfg(1, 2, 2, 3, EXP_ID, 32'd0, 0, 0, 0);
        run_check("T4_ts_bad", 1, 0);
        set_cfg(0, 0, 1, 1, EXP_ID, EXP_TS, 1, 0, 0);
        run_check("T5_no_data", 1, 0);
        set_cfg(16, 0, 1, 1, EXP_ID, EXP_TS, 0, 0, 0);
        run_check("B_accept_last", 1, 0);
        set_cfg(17, 0, 1, 1, EXP_ID, EXP_TS, 0, 0, 0);
        run_check("B_req_expire", 1, 0);
        set_cfg(10, 0, 6, 1, EXP_ID, EXP_TS, 0, 0, 0);
        run_check("B_data_last", 1, 0);
        set_cfg(0, 10, 1, 7, EXP_ID, EXP_TS, 0, 0, 0);
        run_check("B_data_late", 1, 0);
        set_cfg(16, 3, 2, 1, EXP_ID, EXP_TS, 0, 0, 0);
        run_check("B_accept_last_slow", 1, 0);

        for (int i = 0; i < 24; i++) begin
            set_cfg($urandom_range(0, 6), $urandom_range(0, 6),
                    $urandom_range(1, 5), $urandom_range(1, 5),
                    $urandom_range(0, 1) ? EXP_ID : $urandom,
                    $urandom_range(0, 1) ? EXP_TS : $urandom,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                    1'($urandom_range(0, 1)));
            run_check($sformatf("R%0d", i), 1, 1'($urandom_range(0, 1)));
        end

        // T6: reset while waiting for word 1; its data arrives during reset
        set_cfg(0, 0, 1, 3, EXP_ID, EXP_TS, 0, 0, 0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        hit = 0;
        for (int k = 0; k < 50 && !hit; k++) begin
            if (a_read === 1'b1 && wr === 1'b0 && a_addr === 1'b1) hit = 1;
            else @(negedge clk);
        end
        chk("T6.reached_ts", {31'd0, hit}, 1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk_zero("T6.async");
        repeat (4) @(negedge clk);
        chk_zero("T6.held");
        set_cfg(0, 0, 1, 1, EXP_ID, EXP_TS, 0, 0, 0);
        reset_n = 1'b1;
        run_check("T6_after", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
